// File: rtl/nes_pad_emulator.sv
// Emulates the 4021 shift register inside an NES gamepad.
// Returns an 8-bit button vector, active-low, in response to host latch/nes_clk.
module nes_pad_emulator #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch,
    input  logic       nes_clk,
    input  logic [7:0] buttons,
    output logic       data,
    output logic       frame_done,
    output logic       busy,
    output logic [3:0] bit_idx
);

    localparam int unsigned CNT_W   = 20;
    localparam int unsigned SYNC_W  = 3;
    localparam int unsigned NBITS   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               data_q, data_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [SYNC_W-1:0]  latch_sync_q;
    logic [SYNC_W-1:0]  nclk_sync_q;

    logic latch_rise_c, latch_fall_c, nclk_rise_c;

    // Two synchronizer flops, the third holds the previous value for edge detection.
    assign latch_rise_c =  latch_sync_q[1] & ~latch_sync_q[2];
    assign latch_fall_c = ~latch_sync_q[1] &  latch_sync_q[2];
    assign nclk_rise_c  =  nclk_sync_q[1]  & ~nclk_sync_q[2];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        // A latch rise aborts whatever is in progress, nes_clk included.
        if (latch_rise_c) begin
            state_d = LOAD;
            shift_d = ~buttons;
            idx_d   = 4'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    idx_d = 4'd0;
                    cnt_d = '0;
                    if (latch_fall_c) begin
                        state_d = SHIFT;
                    end else begin
                        shift_d = ~buttons;
                    end
                end
                SHIFT: begin
                    if (nclk_rise_c) begin
                        shift_d = {1'b1, shift_q[7:1]};
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = '0;
                        if (idx_q == 4'(NBITS - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == SHIFT);
        data_d = busy_d ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= 8'hFF;
            idx_q        <= 4'd0;
            cnt_q        <= '0;
            data_q       <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            latch_sync_q <= '0;
            nclk_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            latch_sync_q <= {latch_sync_q[SYNC_W-2:0], latch};
            nclk_sync_q  <= {nclk_sync_q[SYNC_W-2:0], nes_clk};
        end
    end

    assign data       = data_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign bit_idx    = idx_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Bench for nes_pad_emulator: host-side stimulus with a scoreboard on the serial stream.
module tb_nes_pad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       data, frame_done, busy;
    logic [3:0] bit_idx;
    logic       to_data, to_frame_done, to_busy;
    logic [3:0] to_bit_idx;

    int errors = 0;
    int checks = 0;
    int to_done_cnt = 0;

    logic exp_q[$];
    bit   done_q[$];

    localparam int HALF = 150;   // 6 us nes_clk period at 50 MHz

    nes_pad_emulator u_dut (
        .clk(clk), .rst(rst), .latch(latch), .nes_clk(nes_clk), .buttons(buttons),
        .data(data), .frame_done(frame_done), .busy(busy), .bit_idx(bit_idx)
    );

    nes_pad_emulator #(.TIMEOUT_CYCLES(100)) u_dut_to (
        .clk(clk), .rst(rst), .latch(latch), .nes_clk(nes_clk), .buttons(buttons),
        .data(to_data), .frame_done(to_frame_done), .busy(to_busy), .bit_idx(to_bit_idx)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host samples data just before each nes_clk rise.
    always @(posedge nes_clk) begin
        logic e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL data_stream: unexpected nes_clk rise, data=%0b at %0t", data, $time);
        end else begin
            e = exp_q.pop_front();
            if (data !== e) begin
                errors++;
                $display("FAIL data_stream: got %0b expected %0b at %0t", data, e, $time);
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL frame_done: got unexpected pulse expected none at %0t", $time);
            end else begin
                void'(done_q.pop_front());
                chk("done_bit_idx", int'(bit_idx), 8);
                chk("done_data", int'(data), 1);
            end
        end
        if (to_frame_done) to_done_cnt++;
    end

    task automatic latch_pulse(input int clks);
        latch = 1'b1;
        tick(clks);
        latch = 1'b0;
        tick(HALF);
    endtask

    // seq[i] is the expected data before rise i; done_rise marks the rise ending the frame.
    task automatic shift_bits(input int n, input logic [15:0] seq, input int done_rise);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            if (i == done_rise) done_q.push_back(1'b1);
            nes_clk = 1'b1;
            tick(HALF);
            nes_clk = 1'b0;
            tick(HALF);
        end
    endtask

    initial begin
        rst = 1'b1; latch = 1'b0; nes_clk = 1'b0; buttons = 8'h5A;
        tick(3);
        chk("rst_data", int'(data), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bit_idx", int'(bit_idx), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        tick(10);
        chk("idle_data", int'(data), 1);
        chk("idle_busy", int'(busy), 0);

        // Full frame, A + Select; ninth rise after DONE
        buttons = 8'b0000_0101;
        latch_pulse(600);
        chk("ff_busy", int'(busy), 1);
        shift_bits(9, 16'b0000_0001_1111_1010, 7);
        chk("ff_bit_idx", int'(bit_idx), 8);
        chk("ff_data", int'(data), 1);
        chk("ff_busy_done", int'(busy), 0);

        // Live load: Right pressed while latch is high, changes after fall ignored
        buttons = 8'h00;
        latch = 1'b1;
        tick(300);
        buttons = 8'h80;
        tick(300);
        latch = 1'b0;
        tick(20);
        buttons = 8'h55;
        tick(HALF - 20);
        shift_bits(8, 16'b0000_0000_0111_1111, 7);
        chk("live_bit_idx", int'(bit_idx), 8);

        // Abort after three shifts
        buttons = 8'h02;
        latch_pulse(600);
        shift_bits(3, 16'b0000_0000_0000_0101, -1);
        chk("abort_pre_idx", int'(bit_idx), 3);
        buttons = 8'hFF;
        latch = 1'b1;
        tick(6);
        chk("abort_bit_idx", int'(bit_idx), 0);
        chk("abort_busy", int'(busy), 1);
        chk("abort_data", int'(data), 0);
        tick(594);
        latch = 1'b0;
        tick(HALF);
        shift_bits(8, 16'h0000, 7);
        chk("abort_frame_idx", int'(bit_idx), 8);

        // Asynchronous reset mid-frame
        buttons = 8'h01;
        latch_pulse(600);
        chk("mid_data_low", int'(data), 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_data", int'(data), 1);
        chk("async_rst_busy", int'(busy), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        to_done_cnt = 0;

        // Timeout on the 100-cycle instance
        latch = 1'b1;
        tick(20);
        latch = 1'b0;
        tick(50);
        chk("to_busy_early", int'(to_busy), 1);
        tick(100);
        chk("to_busy", int'(to_busy), 0);
        chk("to_data", int'(to_data), 1);
        chk("to_bit_idx", int'(to_bit_idx), 0);
        chk("to_no_done", to_done_cnt, 0);
        chk("long_to_busy", int'(busy), 1);

        // Latch fall and nes_clk rise on the same edge
        buttons = 8'h01;
        latch = 1'b1;
        tick(30);
        exp_q.push_back(1'b0);
        latch = 1'b0;
        nes_clk = 1'b1;
        tick(10);
        chk("col_data", int'(data), 0);
        chk("col_bit_idx", int'(bit_idx), 0);
        chk("col_busy", int'(busy), 1);
        tick(HALF - 10);
        nes_clk = 1'b0;
        tick(HALF);
        shift_bits(2, 16'b0000_0000_0000_0010, -1);
        chk("col_after_idx", int'(bit_idx), 2);

        tick(5);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
